rx_fcs_strip: RTL and testbench

Byte-stream post-processor that sits directly downstream of the OFDM decoder's `byte_out`/`byte_out_strobe` on the DATA path.
- Counts PSDU bytes against a length latched at packet start.
- Runs a reflected CRC-32 over every byte and reports FCS pass/fail one cycle after the last byte.
- Forwards payload bytes to the MAC side with the trailing 4 FCS bytes stripped, using a 4-byte delay line.

---
 rtl/rx_fcs_strip.sv | 166 ++++++++++++++++
 tb/tb_rx_fcs_strip.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fcs_strip.sv
// rx_fcs_strip: post-processor for the decoded DATA byte stream.
// It counts PSDU bytes against a length latched at packet start and runs a
// reflected CRC-32 over every byte. Payload is forwarded with the trailing
// 4-byte FCS removed: a 4-byte delay line holds back the newest four bytes,
// and the last four bytes to arrive are never released.
module rx_fcs_strip #(
    parameter int          LEN_WIDTH   = 16,
    parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [7:0]           byte_in,
    input  logic                 byte_in_strobe,
    output logic [7:0]           payload_out,
    output logic                 payload_out_strobe,
    output logic                 payload_last,
    output logic [LEN_WIDTH-1:0] byte_count,
    output logic                 fcs_out_valid,
    output logic                 fcs_ok,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [31:0]          crc;
    logic [31:0]          crc_next;
    // delay_line[0] holds the newest byte, delay_line[3] the oldest.
    logic [3:0][7:0]      delay_line;

    logic                 start_go;
    logic                 accept;
    logic                 last_byte;
    logic                 emit_payload;
    logic [LEN_WIDTH-1:0] last_index;

    // One byte of the reflected CRC: fold the byte into the low bits, then
    // apply eight LSB-first shift/XOR steps. No final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Decode of this cycle's events; start always wins over a byte strobe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        start_go     = 1'b0;
        accept       = 1'b0;
        last_byte    = 1'b0;
        emit_payload = 1'b0;
        last_index   = len_q - LEN_WIDTH'(1);
        crc_next     = crc32_byte(crc, byte_in);

        start_go = enable && start;
        accept   = enable && !start && byte_in_strobe && (state == ST_RUN);

        if (accept) begin
            last_byte    = (byte_count == last_index);
            emit_payload = (byte_count >= LEN_WIDTH'(4)) && (len_q >= LEN_WIDTH'(5));
        end
    end

    assign busy = (state == ST_RUN);

    // Packet state: start (re)opens a packet, the last byte closes it.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
        end else if (start_go) begin
            state <= (pkt_len == '0) ? ST_DONE : ST_RUN;
        end else if (last_byte) begin
            state <= ST_DONE;
        end
    end

    // Packet length, captured only when a packet starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q <= '0;
        end else if (start_go) begin
            len_q <= pkt_len;
        end
    end

    // Count of bytes accepted since the last start.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_count <= '0;
        end else if (start_go) begin
            byte_count <= '0;
        end else if (accept) begin
            byte_count <= byte_count + LEN_WIDTH'(1);
        end
    end

    // Running CRC register, seeded at packet start.
    always_ff @(posedge clock) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (start_go) begin
            crc <= CRC_INIT;
        end else if (accept) begin
            crc <= crc_next;
        end
    end

    // Four-byte holding line that keeps the FCS from reaching the MAC side.
    always_ff @(posedge clock) begin
        // NOTE: the delay line is a handful of flops rather than a RAM, so it takes the reset like any other register.
        if (reset) begin
            delay_line <= '0;
        end else if (accept) begin
            delay_line <= {delay_line[2:0], byte_in};
        end
    end

    // Payload output: release the oldest held byte once four are queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            payload_out        <= 8'd0;
            payload_out_strobe <= 1'b0;
            payload_last       <= 1'b0;
        end else begin
            payload_out_strobe <= 1'b0;
            payload_last       <= 1'b0;
            if (emit_payload) begin
                payload_out        <= delay_line[3];
                payload_out_strobe <= 1'b1;
                payload_last       <= last_byte;
            end
        end
    end

    // FCS verdict: cleared at start, decided on the last byte, held after.
    always_ff @(posedge clock) begin
        if (reset) begin
            fcs_ok        <= 1'b0;
            fcs_out_valid <= 1'b0;
        end else begin
            fcs_out_valid <= 1'b0;
            if (start_go) begin
                fcs_ok        <= 1'b0;
                fcs_out_valid <= (pkt_len == '0);
            end else if (last_byte) begin
                fcs_ok        <= (len_q >= LEN_WIDTH'(4)) && (crc_next == CRC_RESIDUE);
                fcs_out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_fcs_strip.sv
// tb_rx_fcs_strip: directed and randomized frames for rx_fcs_strip.
// The reference is a frame-level model: the accepted bytes are kept in a
// queue, payload bytes are looked up by index, and the FCS verdict is the
// standard CRC-32 of the data portion compared with the appended FCS word.
module tb_rx_fcs_strip;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic [15:0] pkt_len;
    logic [7:0]  byte_in;
    logic        byte_in_strobe;
    logic [7:0]  payload_out;
    logic        payload_out_strobe;
    logic        payload_last;
    logic [15:0] byte_count;
    logic        fcs_out_valid;
    logic        fcs_ok;
    logic        busy;

    rx_fcs_strip #(.LEN_WIDTH(16), .CRC_RESIDUE(32'hDEBB20E3)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .start              (start),
        .pkt_len            (pkt_len),
        .byte_in            (byte_in),
        .byte_in_strobe     (byte_in_strobe),
        .payload_out        (payload_out),
        .payload_out_strobe (payload_out_strobe),
        .payload_last       (payload_last),
        .byte_count         (byte_count),
        .fcs_out_valid      (fcs_out_valid),
        .fcs_ok             (fcs_ok),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    // Reference model state.
    logic [7:0]  acc[$];
    int          m_len;
    bit          m_running;
    logic [15:0] m_count;
    bit          m_fcs_ok;
    int          obs_pay;
    int          obs_fcs;

    logic [7:0] valid_frame[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                   8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard CRC-32 (init all ones, reflected, final inversion) of data[0..n-1].
    function automatic logic [31:0] crc32_of(input logic [7:0] data[$], input int n);
        logic [31:0] c;
        bit fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ data[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic bit model_fcs_ok();
        int n;
        logic [31:0] fcs_word;
        n = acc.size();
        if (n < 4) return 1'b0;
        fcs_word = {acc[n-1], acc[n-2], acc[n-3], acc[n-4]};
        return crc32_of(acc, n - 4) == fcs_word;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (payload_out_strobe) obs_pay++;
        if (fcs_out_valid) obs_fcs++;
    endtask

    task automatic verify(input string tag, input bit e_pstb, input logic [7:0] e_pdata,
                          input bit e_plast, input bit e_fv);
        check({tag, ".pay_stb"}, payload_out_strobe, e_pstb);
        if (e_pstb) check({tag, ".pay_data"}, payload_out, e_pdata);
        check({tag, ".pay_last"}, payload_last, e_plast);
        check({tag, ".fcs_valid"}, fcs_out_valid, e_fv);
        check({tag, ".count"}, byte_count, m_count);
        check({tag, ".busy"}, busy, m_running);
        check({tag, ".fcs_ok"}, fcs_ok, m_fcs_ok);
    endtask

    task automatic do_start(input int len, input bit with_strobe);
        enable = 1'b1; start = 1'b1; pkt_len = 16'(len);
        byte_in_strobe = with_strobe; byte_in = 8'hA5;
        obs_pay = 0; obs_fcs = 0;
        acc.delete();
        m_len = len; m_count = '0; m_fcs_ok = 1'b0; m_running = (len != 0);
        tick();
        start = 1'b0; byte_in_strobe = 1'b0;
        verify("start", 1'b0, 8'h00, 1'b0, len == 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bit e_pay, e_last;
        enable = 1'b1; start = 1'b0; byte_in_strobe = 1'b1; byte_in = b;
        tick();
        byte_in_strobe = 1'b0;
        if (m_running) begin
            k = acc.size();
            acc.push_back(b);
            m_count = 16'(k + 1);
            e_pay  = (k >= 4) && (m_len >= 5);
            e_last = (k == m_len - 1);
            if (e_last) begin
                m_running = 1'b0;
                m_fcs_ok  = model_fcs_ok();
            end
            verify("byte", e_pay, e_pay ? acc[k-4] : 8'h00, e_pay && e_last, e_last);
        end else begin
            verify("ignored", 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1; start = 1'b0; byte_in_strobe = 1'b0;
            tick();
            verify("idle", 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    // Strobes (and sometimes start) with enable low: nothing may change.
    task automatic disabled(input logic [7:0] b);
        enable = 1'b0; start = 1'($urandom_range(0, 1)); pkt_len = 16'd2;
        byte_in_strobe = 1'b1; byte_in = b;
        tick();
        enable = 1'b1; start = 1'b0; byte_in_strobe = 1'b0;
        verify("disabled", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap);
        do_start(f.size(), 1'b0);
        foreach (f[i]) begin
            send_byte(f[i]);
            idle(gap);
        end
        check("frame.pay_total", obs_pay, (f.size() >= 5) ? f.size() - 4 : 0);
        check("frame.fcs_pulses", obs_fcs, 1);
    endtask

    initial begin
        logic [7:0] f[$];
        logic [31:0] c;
        int n;

        reset = 1'b1; enable = 1'b0; start = 1'b0; pkt_len = '0;
        byte_in = '0; byte_in_strobe = 1'b0;
        m_running = 1'b0; m_count = '0; m_fcs_ok = 1'b0; m_len = 0;
        obs_pay = 0; obs_fcs = 0;
        tick();
        tick();
        check("reset.pay_out", payload_out, 8'h00);
        verify("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        idle(2);

        // Valid frame, back-to-back strobes.
        send_frame(valid_frame, 0);
        check("valid.fcs_ok", fcs_ok, 1'b1);
        check("valid.count", byte_count, 16'd13);
        idle(2);

        // Corrupted frame, strobes spaced by three idle cycles.
        f = valid_frame;
        f[4] = 8'h34;
        send_frame(f, 3);
        check("corrupt.fcs_ok", fcs_ok, 1'b0);

        // Short lengths.
        f = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        check("len4.fcs_ok", fcs_ok, 1'b1);
        f = '{8'h12, 8'h34, 8'h56};
        send_frame(f, 1);
        check("len3.fcs_ok", fcs_ok, 1'b0);
        do_start(0, 1'b1);
        check("len0.fcs_valid", fcs_out_valid, 1'b1);
        check("len0.fcs_ok", fcs_ok, 1'b0);
        idle(2);

        // Restart after 6 bytes; only the second packet may report.
        do_start(13, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(valid_frame[i]);
        do_start(13, 1'b1);
        foreach (valid_frame[i]) send_byte(valid_frame[i]);
        check("restart.pay_total", obs_pay, 9);
        check("restart.fcs_pulses", obs_fcs, 1);
        check("restart.fcs_ok", fcs_ok, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'hEE);
        check("restart.done_count", byte_count, 16'd13);

        // Enable low for five strobed cycles, then the same bytes re-sent.
        do_start(13, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(valid_frame[i]);
        for (int i = 5; i < 10; i++) disabled(valid_frame[i]);
        for (int i = 5; i < 13; i++) send_byte(valid_frame[i]);
        check("enable.fcs_ok", fcs_ok, 1'b1);
        check("enable.pay_total", obs_pay, 9);

        // Reset in the middle of a packet.
        do_start(13, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(valid_frame[i]);
        reset = 1'b1; byte_in_strobe = 1'b1; byte_in = valid_frame[7];
        tick();
        reset = 1'b0; byte_in_strobe = 1'b0;
        m_running = 1'b0; m_count = '0; m_fcs_ok = 1'b0;
        check("midreset.pay_out", payload_out, 8'h00);
        verify("midreset", 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);

        // Randomized frames: random length, data, gaps, enable drops and corruption.
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 30);
            f.delete();
            if (n >= 4) begin
                for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
                c = crc32_of(f, n - 4);
                f.push_back(c[7:0]);
                f.push_back(c[15:8]);
                f.push_back(c[23:16]);
                f.push_back(c[31:24]);
                if ($urandom_range(0, 3) == 0) begin
                    n = $urandom_range(0, f.size() - 1);
                    f[n] = f[n] ^ (8'd1 << $urandom_range(0, 7));
                end
            end else begin
                for (int i = 0; i < n; i++) f.push_back(8'($urandom));
            end
            do_start(f.size(), 1'($urandom_range(0, 1)));
            foreach (f[i]) begin
                if ($urandom_range(0, 7) == 0) disabled(8'($urandom));
                send_byte(f[i]);
                idle($urandom_range(0, 2));
            end
            check("rand.pay_total", obs_pay, (f.size() >= 5) ? f.size() - 4 : 0);
            check("rand.fcs_pulses", obs_fcs, 1);
            idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
